// File: rtl/alu_pkg.sv
// alu_pkg: shared types for the alu_pipe execution unit.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
// Contents: alu_op_e (5-bit op codes), alu_state_e, ALU_OP_W, is_multicycle().
package alu_pkg;

    localparam int ALU_OP_W = 5;

    typedef enum logic [ALU_OP_W-1:0] {
        OP_ADD    = 5'd0,
        OP_SUB    = 5'd1,
        OP_SLT    = 5'd2,
        OP_SLTU   = 5'd3,
        OP_XOR    = 5'd4,
        OP_OR     = 5'd5,
        OP_AND    = 5'd6,
        OP_SLL    = 5'd7,
        OP_SRL    = 5'd8,
        OP_SRA    = 5'd9,
        OP_MUL    = 5'd16,
        OP_MULH   = 5'd17,
        OP_MULHSU = 5'd18,
        OP_MULHU  = 5'd19,
        OP_DIV    = 5'd20,
        OP_DIVU   = 5'd21,
        OP_REM    = 5'd22,
        OP_REMU   = 5'd23
    } alu_op_e;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_BUSY = 1'b1
    } alu_state_e;

    // Codes 16..23 form the mul/div group.
    function automatic logic is_multicycle(input logic [ALU_OP_W-1:0] op);
        return (op[4:3] == 2'b10);
    endfunction

endpackage

// File: rtl/alu_muldiv_iter.sv
// alu_muldiv_iter: iterative radix-2 multiply / restoring divide, one bit per clk.
// Latency: start edge loads operands, WIDTH iteration edges follow, done is high for one cycle after them.
// Backpressure: none; the caller holds off new starts until done. Built only with ALU_PIPE_MULDIV_EN.
// Ports: clk, rst (sync, active high), start, op, a, b -> done, result.
`ifdef ALU_PIPE_MULDIV_EN
module alu_muldiv_iter
    import alu_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [ALU_OP_W-1:0] op,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    output logic                done,
    output logic [WIDTH-1:0]    result
);
    localparam int CNT_W = $clog2(WIDTH) + 1;

    logic             busy_q;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] hi_q, lo_q, den_q;
    logic             is_div_q, neg_q, sel_hi_q, dz_q;

    // Operand conditioning at start: work on magnitudes, remember the sign to restore.
    logic             sgn_a, sgn_b, sa, sb, div_op;
    logic [WIDTH-1:0] abs_a, abs_b;

    always_comb begin
        sgn_a  = (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
        sgn_b  = (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
        div_op = (op == OP_DIV) || (op == OP_DIVU) || (op == OP_REM) || (op == OP_REMU);
        sa     = sgn_a && a[WIDTH-1];
        sb     = sgn_b && b[WIDTH-1];
        abs_a  = sa ? -a : a;
        abs_b  = sb ? -b : b;
    end

    // One iteration step for each flavour.
    logic [WIDTH:0] sum, rr, diff;

    always_comb begin
        sum  = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : {(WIDTH+1){1'b0}});
        rr   = {hi_q, lo_q[WIDTH-1]};
        diff = rr - {1'b0, den_q};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            busy_q   <= 1'b0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            den_q    <= '0;
            is_div_q <= 1'b0;
            neg_q    <= 1'b0;
            sel_hi_q <= 1'b0;
            dz_q     <= 1'b0;
        end else if (start) begin
            busy_q   <= 1'b1;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= abs_a;
            den_q    <= abs_b;
            is_div_q <= div_op;
            // MUL needs no fix-up: the low half is signedness-agnostic.
            neg_q    <= ((op == OP_MULH) || (op == OP_DIV)) ? (sa ^ sb) : sa;
            sel_hi_q <= (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_MULHU)
                        || (op == OP_REM) || (op == OP_REMU);
            // Signed DIV by zero must not take the sign fix-up path.
            dz_q     <= (b == '0) && ((op == OP_DIV) || (op == OP_DIVU));
        end else if (busy_q) begin
            if (cnt_q == CNT_W'(WIDTH)) begin
                busy_q <= 1'b0;
            end else begin
                cnt_q <= cnt_q + 1'b1;
                if (is_div_q) begin
                    // Remainder in hi, dividend shifting out of lo while quotient bits shift in.
                    hi_q <= diff[WIDTH] ? rr[WIDTH-1:0] : diff[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], ~diff[WIDTH]};
                end else begin
                    // Multiplier consumed from lo[0]; product shifts right across {hi,lo}.
                    hi_q <= sum[WIDTH:1];
                    lo_q <= {sum[0], lo_q[WIDTH-1:1]};
                end
            end
        end
    end

    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   dv;

    always_comb begin
        prod = neg_q ? -{hi_q, lo_q} : {hi_q, lo_q};
        dv   = sel_hi_q ? hi_q : lo_q;
        if (is_div_q) begin
            result = dz_q ? '1 : (neg_q ? -dv : dv);
        end else begin
            result = sel_hi_q ? prod[2*WIDTH-1:WIDTH] : prod[WIDTH-1:0];
        end
    end

    assign done = busy_q && (cnt_q == CNT_W'(WIDTH));

endmodule
`endif

// File: rtl/alu_pipe.sv
// alu_pipe: handshaked ALU; ALU_PIPE_MULDIV_EN adds iterative mul/div ops 16..23.
// Latency: 1 clk for single-cycle ops, WIDTH+1 clks for mul/div (in_ready low while BUSY).
// Backpressure: result held until out_ready; in_ready = !rst && IDLE && (!out_valid || out_ready).
// Ports: clk, rst (sync, active high), in_valid/in_ready/a/b/op, out_valid/out_ready/result.
module alu_pipe
    import alu_pkg::*;
#(
    parameter  int WIDTH   = 32,
    localparam int SHAMT_W = $clog2(WIDTH)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [WIDTH-1:0]    a,
    input  logic [WIDTH-1:0]    b,
    input  logic [ALU_OP_W-1:0] op,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WIDTH-1:0]    result
);
    alu_state_e       state_q, state_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic [WIDTH-1:0] alu_res;
    logic [SHAMT_W-1:0] shamt;
    logic             accept;

    assign in_ready = !rst && (state_q == ST_IDLE) && (!out_valid_q || out_ready);
    assign accept   = in_valid && in_ready;

    // Single-cycle datapath; anything not listed (incl. mul/div codes when disabled) yields 0.
    always_comb begin
        shamt   = b[SHAMT_W-1:0];
        alu_res = '0;
        case (op)
            OP_ADD:  alu_res = a + b;
            OP_SUB:  alu_res = a - b;
            OP_SLT:  alu_res = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: alu_res = {{(WIDTH-1){1'b0}}, (a < b)};
            OP_XOR:  alu_res = a ^ b;
            OP_OR:   alu_res = a | b;
            OP_AND:  alu_res = a & b;
            OP_SLL:  alu_res = a << shamt;
            OP_SRL:  alu_res = a >> shamt;
            OP_SRA:  alu_res = WIDTH'($signed(a) >>> shamt);
            default: alu_res = '0;
        endcase
    end

`ifdef ALU_PIPE_MULDIV_EN
    logic             md_start, md_done;
    logic [WIDTH-1:0] md_result;

    alu_muldiv_iter #(.WIDTH(WIDTH)) u_muldiv (
        .clk    (clk),
        .rst    (rst),
        .start  (md_start),
        .op     (op),
        .a      (a),
        .b      (b),
        .done   (md_done),
        .result (md_result)
    );
`endif

    always_comb begin
        state_d     = state_q;
        out_valid_d = out_valid_q && !out_ready;
        result_d    = result_q;
`ifdef ALU_PIPE_MULDIV_EN
        md_start    = 1'b0;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept) begin
`ifdef ALU_PIPE_MULDIV_EN
                    if (is_multicycle(op)) begin
                        state_d  = ST_BUSY;
                        md_start = 1'b1;
                    end else
`endif
                    begin
                        out_valid_d = 1'b1;
                        result_d    = alu_res;
                    end
                end
            end
            ST_BUSY: begin
`ifdef ALU_PIPE_MULDIV_EN
                // out_valid is already low here: entering BUSY required a free output slot.
                if (md_done) begin
                    state_d     = ST_IDLE;
                    out_valid_d = 1'b1;
                    result_d    = md_result;
                end
`else
                state_d = ST_IDLE;
`endif
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            out_valid_q <= 1'b0;
            result_q    <= '0;
        end else begin
            state_q     <= state_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
        end
    end

    assign out_valid = out_valid_q;
    assign result    = result_q;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: self-checking bench for alu_pipe (WIDTH=32).
// Latency: checks 1-clk single-cycle latency and WIDTH+1 mul/div latency when ALU_PIPE_MULDIV_EN is set.
// Backpressure: exercises out_ready stalls, pop-and-accept in one cycle and random handshakes.
module tb_alu_pipe;
    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst, in_valid, in_ready, out_valid, out_ready;
    logic [W-1:0]  a, b, result;
    logic [4:0]    op;

    always #5 clk = ~clk;

    alu_pipe #(.WIDTH(W)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference model: plain integer arithmetic on 64-bit values.
    function automatic logic [31:0] model(input logic [4:0] o, input logic [31:0] x, input logic [31:0] y);
        longint      sx = longint'($signed(x));
        longint      sy = longint'($signed(y));
        logic [63:0] ux = {32'b0, x};
        logic [63:0] uy = {32'b0, y};
        logic [63:0] p;
        int          sh = int'(y[4:0]);
        case (o)
            5'd0: return x + y;
            5'd1: return x - y;
            5'd2: return (sx < sy) ? 32'd1 : 32'd0;
            5'd3: return (x < y) ? 32'd1 : 32'd0;
            5'd4: return x ^ y;
            5'd5: return x | y;
            5'd6: return x & y;
            5'd7: return x << sh;
            5'd8: return x >> sh;
            5'd9: return 32'(sx >>> sh);
`ifdef ALU_PIPE_MULDIV_EN
            5'd16: begin p = ux * uy; return p[31:0]; end
            5'd17: return 32'((sx * sy) >>> 32);
            5'd18: return 32'((sx * longint'(ux)) >>> 32);
            5'd19: begin p = ux * uy; return p[63:32]; end
            5'd20: return (y == 0) ? 32'hFFFFFFFF : 32'(sx / sy);
            5'd21: return (y == 0) ? 32'hFFFFFFFF : x / y;
            5'd22: return (y == 0) ? x : 32'(sx % sy);
            5'd23: return (y == 0) ? x : x % y;
`endif
            default: return 32'd0;
        endcase
    endfunction

    typedef struct {
        logic [4:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] exp;
    } vec_t;

    vec_t vt[15];

`ifdef ALU_PIPE_MULDIV_EN
    // Accept one mul/div op, then measure the cycles until out_valid.
    task automatic run_mc(input string name, input logic [4:0] o, input logic [31:0] x,
                          input logic [31:0] y, input logic [31:0] expv);
        int lat = 0;
        logic [31:0] got = 32'd0;
        @(negedge clk);
        in_valid = 1'b1; op = o; a = x; b = y; out_ready = 1'b1;
        #1 chk({name, "_rdy"}, {31'b0, in_ready}, 32'd1);
        @(posedge clk);
        #1 in_valid = 1'b0; a = 32'h5A5A5A5A; b = 32'h1;
        for (int c = 1; c <= 40 && lat == 0; c++) begin
            @(negedge clk);
            if (c == 16) chk({name, "_busy_rdy"}, {31'b0, in_ready}, 32'd0);
            if (out_valid) begin
                lat = c;
                got = result;
            end
        end
        chk({name, "_lat"}, lat, 33);
        chk({name, "_res"}, got, expv);
    endtask
`endif

    initial begin
        logic [31:0] q[$];
        int          vcount;

        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; op = 5'd0; a = '0; b = '0;

        vt[0]  = '{5'd0,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vt[1]  = '{5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE};
        vt[2]  = '{5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000};
        vt[3]  = '{5'd0,  32'h00001234, 32'h00000001, 32'h00001235};
        vt[4]  = '{5'd2,  32'hFFFFFFFF, 32'h00000001, 32'h00000001};
        vt[5]  = '{5'd3,  32'hFFFFFFFF, 32'h00000001, 32'h00000000};
        vt[6]  = '{5'd2,  32'h00000001, 32'hFFFFFFFF, 32'h00000000};
        vt[7]  = '{5'd9,  32'h80000000, 32'h00000021, 32'hC0000000};
        vt[8]  = '{5'd8,  32'h80000000, 32'h00000021, 32'h40000000};
        vt[9]  = '{5'd7,  32'h00000001, 32'h0000003F, 32'h80000000};
        vt[10] = '{5'd4,  32'hF0F0F0F0, 32'hFF00FF00, 32'h0FF00FF0};
        vt[11] = '{5'd5,  32'h0F000000, 32'h000000F0, 32'h0F0000F0};
        vt[12] = '{5'd6,  32'hF0F0F0F0, 32'hFF00FF00, 32'hF000F000};
        vt[13] = '{5'd15, 32'h12345678, 32'h00000009, 32'h00000000};
        vt[14] = '{5'd1,  32'h00000000, 32'h00000001, 32'hFFFFFFFF};

        // Reset state
        repeat (2) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", result, 32'd0);
        chk("rst_rdy", {31'b0, in_ready}, 32'd0);
        rst = 1'b0;
        #1 chk("post_rst_rdy", {31'b0, in_ready}, 32'd1);

        // Reset mid-stream with a pending result
        @(negedge clk);
        in_valid = 1'b1; op = 5'd0; a = 32'd3; b = 32'd4; out_ready = 1'b0;
        @(negedge clk);
        chk("pend_valid", {31'b0, out_valid}, 32'd1);
        chk("pend_result", result, 32'd7);
        rst = 1'b1;
        #1 chk("mid_rst_rdy", {31'b0, in_ready}, 32'd0);
        repeat (2) @(negedge clk);
        chk("mid_rst_valid", {31'b0, out_valid}, 32'd0);
        chk("mid_rst_result", result, 32'd0);
        rst = 1'b0; in_valid = 1'b0;
        #1 chk("mid_rst_rdy_after", {31'b0, in_ready}, 32'd1);

        // Table: back-to-back, one result per clock
        @(negedge clk);
        out_ready = 1'b1;
        for (int i = 0; i < 15; i++) begin
            in_valid = 1'b1; op = vt[i].op; a = vt[i].a; b = vt[i].b;
            #1 chk($sformatf("tbl%0d_rdy", i), {31'b0, in_ready}, 32'd1);
            @(negedge clk);
            chk($sformatf("tbl%0d_valid", i), {31'b0, out_valid}, 32'd1);
            chk($sformatf("tbl%0d_res", i), result, vt[i].exp);
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("tbl_drain_valid", {31'b0, out_valid}, 32'd0);

        // Backpressure: result held 3 clks, next op accepted in the pop cycle
        in_valid = 1'b1; op = 5'd0; a = 32'd10; b = 32'd20; out_ready = 1'b0;
        @(negedge clk);
        op = 5'd4; a = 32'hFF; b = 32'h0F;
        repeat (3) begin
            #1;
            chk("bp_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_hold", result, 32'd30);
            chk("bp_rdy", {31'b0, in_ready}, 32'd0);
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1 chk("bp_release_rdy", {31'b0, in_ready}, 32'd1);
        @(negedge clk);
        chk("bp_next_valid", {31'b0, out_valid}, 32'd1);
        chk("bp_next_res", result, 32'hF0);
        in_valid = 1'b0;
        @(negedge clk);
        chk("bp_empty", {31'b0, out_valid}, 32'd0);

`ifdef ALU_PIPE_MULDIV_EN
        run_mc("mulh", 5'd17, 32'h80000000, 32'h80000000, 32'h40000000);
        run_mc("div", 5'd20, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD);
        run_mc("rem", 5'd22, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF);
        run_mc("divu0", 5'd21, 32'h12345678, 32'd0, 32'hFFFFFFFF);
        run_mc("div0", 5'd20, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFFF);
        run_mc("rem0", 5'd22, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9);
        run_mc("divovf", 5'd20, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
        run_mc("removf", 5'd22, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
        run_mc("mulhsu", 5'd18, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Reset while BUSY: the aborted op never produces a result
        @(negedge clk);
        in_valid = 1'b1; op = 5'd20; a = 32'd100; b = 32'd7; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        repeat (10) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        vcount = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge clk);
            if (out_valid) vcount++;
        end
        chk("busy_rst_no_valid", vcount, 0);
        run_mc("after_rst", 5'd21, 32'd100, 32'd7, 32'd14);
`endif

        // Random handshakes against the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            op = 5'($urandom_range(0, 31));
            a  = ($urandom_range(0, 7) == 0) ? 32'h80000000 : $urandom;
            case ($urandom_range(0, 7))
                0: b = 32'd0;
                1: b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            #1;
            if (out_valid && out_ready) begin
                if (q.size() == 0) chk("rnd_spurious", 32'd1, 32'd0);
                else chk("rnd_res", result, q.pop_front());
            end
            if (in_valid && in_ready) q.push_back(model(op, a, b));
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        for (int c = 0; c < 100 && q.size() > 0; c++) begin
            #1;
            if (out_valid) chk("rnd_drain_res", result, q.pop_front());
            @(negedge clk);
        end
        chk("rnd_drain_empty", q.size(), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
